// File: rtl/fp8_to_fixed_converter.sv
// rtl/fp8_to_fixed_converter.sv - iterative FP8 (1/4/3, bias 7) to signed fixed-point converter
// One magnitude shift per clock; valid/ready handshake on input and output.
module fp8_to_fixed_converter #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_fp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OUT_W-1:0] r_mag;
  logic [OUT_W-1:0] r_out_data;
  logic [4:0]       r_cnt;
  logic             r_dir_left;
  logic             r_sat;
  logic             r_sign;
  logic             r_out_sat;

  logic [3:0]        w_exp;
  logic [3:0]        w_sig;
  logic [3:0]        w_e_eff;
  logic signed [6:0] w_k;
  logic [4:0]        w_k_abs;
  logic              w_sat;
  logic              w_accept;
  logic [OUT_W-1:0]  w_result;

  // Decode: shift k = e_eff - 10 + FRAC_W places the 4-bit significand at the output binary point.
  always_comb begin
    w_exp   = in_fp[6:3];
    w_sig   = (w_exp == 4'd0) ? {1'b0, in_fp[2:0]} : {1'b1, in_fp[2:0]};
    w_e_eff = (w_exp == 4'd0) ? 4'd1 : w_exp;
    w_k     = 7'(int'(w_e_eff) + FRAC_W - 10);
    w_k_abs = w_k[6] ? 5'(-w_k) : 5'(w_k);
    w_sat   = (w_exp == 4'hF) || (int'(w_k) > OUT_W - 5);
  end

  assign w_accept = in_valid && (r_state == ST_IDLE);

  always_comb begin
    w_result = r_sign ? (~r_mag + 1'b1) : r_mag;
    if (r_sat) begin
      w_result = r_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 5'd0) w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_dir_left <= 1'b0;
      r_sat      <= 1'b0;
      r_sign     <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mag      <= {{(OUT_W-4){1'b0}}, w_sig};
            r_cnt      <= w_sat ? 5'd0 : w_k_abs;
            r_dir_left <= (w_k > 7'sd0);
            r_sat      <= w_sat;
            r_sign     <= in_fp[7];
          end
        end
        ST_SHIFT: begin
          // Right shifts drop bits, i.e. truncate the magnitude toward zero.
          if (r_cnt != 5'd0) begin
            r_mag <= r_dir_left ? (r_mag << 1) : (r_mag >> 1);
            r_cnt <= r_cnt - 5'd1;
          end else begin
            r_out_data <= w_result;
            r_out_sat  <= r_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fp8_to_fixed_converter.sv
// tb/tb_fp8_to_fixed_converter.sv - directed vector bench for fp8_to_fixed_converter
module tb_fp8_to_fixed_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_fp = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp8_to_fixed_converter #(.OUT_W(16), .FRAC_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  typedef struct {
    logic [7:0]  fp;
    logic [15:0] data;
    logic        sat;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents fp, waits for result, returns latency in edges after accept (99 on timeout).
  task automatic run_conv(input logic [7:0] fp, output int lat);
    @(negedge clk);
    in_fp = fp;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_handshake_out_valid", 32'(out_valid), 32'd0);
    check("idle_after_handshake_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] held;

    vecs[0]  = '{8'h38, 16'h0010, 1'b0, 2};
    vecs[1]  = '{8'hC5, 16'hFFCC, 1'b0, 3};
    vecs[2]  = '{8'h77, 16'h0F00, 1'b0, 9};
    vecs[3]  = '{8'h01, 16'h0000, 1'b0, 6};
    vecs[4]  = '{8'h80, 16'h0000, 1'b0, 6};
    vecs[5]  = '{8'h78, 16'h7FFF, 1'b1, 1};
    vecs[6]  = '{8'hFF, 16'h8000, 1'b1, 1};
    vecs[7]  = '{8'h30, 16'h0008, 1'b0, 1};
    vecs[8]  = '{8'h50, 16'h0080, 1'b0, 5};
    vecs[9]  = '{8'h6F, 16'h0780, 1'b0, 8};
    vecs[10] = '{8'hF0, 16'hF800, 1'b0, 9};
    vecs[11] = '{8'h1C, 16'h0001, 1'b0, 4};
    vecs[12] = '{8'h9C, 16'hFFFF, 1'b0, 4};
    vecs[13] = '{8'h7C, 16'h7FFF, 1'b1, 1};
    vecs[14] = '{8'h87, 16'h0000, 1'b0, 6};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sat", 32'(out_sat), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_conv(vecs[i].fp, lat);
      check($sformatf("lat_%02h", vecs[i].fp), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("data_%02h", vecs[i].fp), 32'(out_data), 32'(vecs[i].data));
      check($sformatf("sat_%02h", vecs[i].fp), 32'(out_sat), 32'(vecs[i].sat));
      release_out();
    end

    // Backpressure: result held, input blocked, stray in_valid not captured.
    run_conv(8'hC5, lat);
    held = out_data;
    check("bp_data", 32'(held), 32'h0000FFCC);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_fp = 8'h38;
      in_valid = (c == 2);
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_stable", 32'(out_data), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_out();
    repeat (4) @(posedge clk);
    #1;
    check("bp_not_captured", 32'(out_valid), 32'd0);
    check("bp_still_idle", 32'(in_ready), 32'd1);

    // Reset mid-SHIFT discards the conversion.
    @(negedge clk);
    in_fp = 8'h77;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", 32'(out_data), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    check("rst_mid_no_result", 32'(out_valid), 32'd0);
    run_conv(8'h38, lat);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_data", 32'(out_data), 32'h00000010);
    check("post_rst_sat", 32'(out_sat), 32'd0);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
